// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared constants for the I2C responder: FSM encodings, ACK levels, widths and address helper.
package i2c_slave_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_ADDR      = 3'd1;
    localparam logic [ST_W-1:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [ST_W-1:0] ST_RX_BYTE   = 3'd3;
    localparam logic [ST_W-1:0] ST_RX_ACK    = 3'd4;
    localparam logic [ST_W-1:0] ST_TX_BYTE   = 3'd5;
    localparam logic [ST_W-1:0] ST_TX_ACK    = 3'd6;
    localparam logic [ST_W-1:0] ST_WAIT_STOP = 3'd7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Address byte carries the 7-bit address in [7:1] and R/W in [0].
    function automatic logic addr_hit(input logic [BYTE_W-1:0] addr_byte, input logic [6:0] slave);
        return addr_byte[7:1] == slave;
    endfunction

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Pad-side and local register-side signals of the I2C responder.
interface i2c_slave_ctrl_if;
    import i2c_slave_ctrl_pkg::*;

    logic              scl;
    logic              sda;
    logic              sda_oe;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_req;
    logic              addressed;
    logic              rw;
    logic              busy;

    modport slave (
        input  scl, sda, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, addressed, rw, busy
    );

    modport master (
        output scl, sda, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, addressed, rw, busy
    );

endinterface

// File: rtl/i2c_slave_ctrl_line_sync.sv
// SCL/SDA synchronizer with registered edge, START and STOP detection.
module i2c_slave_ctrl_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    start,
    output logic stop,
    output logic sda
);

    localparam int unsigned WARM   = SYNC_STAGES + 1;
    localparam int unsigned WARM_W = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic [WARM_W-1:0]      warm;
    logic                   scl_s_c;
    logic                   sda_s_c;
    logic                   primed_c;

    assign scl_s_c  = scl_sync[SYNC_STAGES-1];
    assign sda_s_c  = sda_sync[SYNC_STAGES-1];
    // Events stay masked until the chain and previous-value registers hold real pin values.
    assign primed_c = (warm == WARM_W'(WARM));

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            warm     <= '0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
            scl_prev <= scl_s_c;
            sda_prev <= sda_s_c;
            warm     <= primed_c ? warm : warm + WARM_W'(1);
            scl_rise <= primed_c &  scl_s_c & ~scl_prev;
            scl_fall <= primed_c & ~scl_s_c &  scl_prev;
            start    <= primed_c &  scl_s_c &  scl_prev &  sda_prev & ~sda_s_c;
            stop     <= primed_c &  scl_s_c &  scl_prev & ~sda_prev &  sda_s_c;
            sda      <= sda_s_c;
        end
    end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C responder byte controller: address match, ACK generation, byte receive and transmit.
module i2c_slave_ctrl
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    i2c_slave_ctrl_if.slave  bus
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;

    i2c_slave_ctrl_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (Clk),
        .rst      (Rst),
        .scl_pin  (bus.scl),
        .sda_pin  (bus.sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    logic [ST_W-1:0]   state,     state_n;
    logic [BYTE_W-1:0] shift,     shift_n;
    logic [CNT_W-1:0]  cnt,       cnt_n;
    logic [BYTE_W-1:0] rx_data,   rx_data_n;
    logic              oe,        oe_n;
    logic              rx_valid,  rx_valid_n;
    logic              tx_req,    tx_req_n;
    logic              addressed, addressed_n;
    logic              rw,        rw_n;
    logic              busy,      busy_n;
    logic              mack,      mack_n;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            shift     <= '0;
            cnt       <= '0;
            rx_data   <= '0;
            oe        <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            mack      <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            cnt       <= cnt_n;
            rx_data   <= rx_data_n;
            oe        <= oe_n;
            rx_valid  <= rx_valid_n;
            tx_req    <= tx_req_n;
            addressed <= addressed_n;
            rw        <= rw_n;
            busy      <= busy_n;
            mack      <= mack_n;
        end
    end

    // Next-state logic; in the ACK states the held oe level marks the second half of the slot.
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        cnt_n       = cnt;
        rx_data_n   = rx_data;
        oe_n        = oe;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        addressed_n = addressed;
        rw_n        = rw;
        busy_n      = busy;
        mack_n      = mack;

        if (start) begin
            state_n     = ST_ADDR;
            cnt_n       = '0;
            oe_n        = 1'b0;
            busy_n      = 1'b1;
            addressed_n = 1'b0;
            mack_n      = 1'b0;
        end else if (stop) begin
            state_n     = ST_IDLE;
            oe_n        = 1'b0;
            busy_n      = 1'b0;
            addressed_n = 1'b0;
            mack_n      = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda};
                        cnt_n   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            if (addr_hit(shift_n, SLAVE_ADDR)) begin
                                rw_n    = sda;
                                state_n = ST_ADDR_ACK;
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe) begin
                            oe_n        = ~ACK;
                            addressed_n = 1'b1;
                            tx_req_n    = rw;
                        end else if (rw) begin
                            shift_n = bus.tx_data;
                            oe_n    = ~bus.tx_data[7];
                            state_n = ST_TX_BYTE;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda};
                        cnt_n   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            rx_data_n  = shift_n;
                            rx_valid_n = 1'b1;
                            state_n    = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!oe) begin
                            oe_n = ~ACK;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = ST_RX_BYTE;
                        end
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        if (cnt == CNT_W'(7)) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = ST_TX_ACK;
                        end else begin
                            cnt_n   = cnt + CNT_W'(1);
                            shift_n = {shift[6:0], shift[7]};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && !mack) begin
                        if (sda == NACK) begin
                            addressed_n = 1'b0;
                            state_n     = ST_WAIT_STOP;
                        end else begin
                            tx_req_n = 1'b1;
                            mack_n   = 1'b1;
                        end
                    end else if (scl_fall && mack) begin
                        shift_n = bus.tx_data;
                        oe_n    = ~bus.tx_data[7];
                        mack_n  = 1'b0;
                        state_n = ST_TX_BYTE;
                    end
                end
                default: begin
                    oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe    = oe;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.tx_req    = tx_req;
    assign bus.addressed = addressed;
    assign bus.rw        = rw;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: bit-banged I2C master plus a scoreboard on the local side.
module tb_i2c_slave_ctrl;
    import i2c_slave_ctrl_pkg::*;

    localparam int unsigned Q = 10;

    typedef struct packed {
        logic       is_rx;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_m = 8'h00;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   rx_pulses = 0;
    int   tx_pulses = 0;
    int   oe_cycles = 0;
    exp_t sb[$];

    i2c_slave_ctrl_if bus();

    assign bus.scl     = scl_m;
    assign bus.sda     = sda_m & ~bus.sda_oe;
    assign bus.tx_data = tx_m;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every local-side pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.sda_oe) oe_cycles++;
            if (bus.rx_valid) begin
                rx_pulses++;
                if (sb.size() == 0) check("rx_valid_unexpected", 32'(sb.size()), 32'd1);
                else begin
                    e = sb.pop_front();
                    check("rx_kind", 32'(e.is_rx), 32'd1);
                    check("rx_data", 32'(bus.rx_data), 32'(e.val));
                end
            end
            if (bus.tx_req) begin
                tx_pulses++;
                if (sb.size() == 0) check("tx_req_unexpected", 32'(sb.size()), 32'd1);
                else begin
                    e = sb.pop_front();
                    check("tx_req_kind", 32'(e.is_rx), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;   wq();
        scl_m = 1'b1; wq();
        r = bus.sda;  wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(ack, r);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0, oe0;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'h00);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_addressed", 32'(bus.addressed), 32'd0);
        wq();

        // Write 0x50: address and one data byte.
        rx0 = rx_pulses;
        i2c_start();
        check("wr_busy_after_start", 32'(bus.busy), 32'd1);
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'(ACK));
        check("wr_addressed", 32'(bus.addressed), 32'd1);
        check("wr_rw", 32'(bus.rw), 32'd0);
        sb.push_back('{is_rx: 1'b1, val: 8'hA5});
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        wq();
        check("wr_busy_after_stop", 32'(bus.busy), 32'd0);
        check("wr_rx_data_level", 32'(bus.rx_data), 32'hA5);
        check("wr_rx_pulses", 32'(rx_pulses - rx0), 32'd1);

        // Foreign address is ignored; 0x50 still answers afterwards.
        oe0 = oe_cycles;
        i2c_start();
        write_byte(8'hA2, ack);
        check("miss_nack", 32'(ack), 32'd1);
        check("miss_no_drive", 32'(oe_cycles - oe0), 32'd0);
        check("miss_addressed", 32'(bus.addressed), 32'd0);
        i2c_start();
        write_byte(8'hA0, ack);
        check("miss_then_hit_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        wq();

        // Master read of two bytes, ACK then NACK.
        tx0 = tx_pulses;
        tx_m = 8'h3C;
        sb.push_back('{is_rx: 1'b0, val: 8'h00});
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'(ACK));
        check("rd_rw", 32'(bus.rw), 32'd1);
        tx_m = 8'hC3;
        sb.push_back('{is_rx: 1'b0, val: 8'h00});
        read_byte(1'b0, d);
        check("rd_byte0", 32'(d), 32'h3C);
        read_byte(1'b1, d);
        check("rd_byte1", 32'(d), 32'hC3);
        check("rd_addressed_after_nack", 32'(bus.addressed), 32'd0);
        i2c_stop();
        wq();
        check("rd_tx_req_count", 32'(tx_pulses - tx0), 32'd2);
        check("rd_state_idle", 32'(dut.state), 32'(ST_IDLE));

        // Write then repeated START into a read.
        sb.push_back('{is_rx: 1'b1, val: 8'h11});
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        check("rs_data_ack", 32'(ack), 32'(ACK));
        tx_m = 8'h5A;
        sb.push_back('{is_rx: 1'b0, val: 8'h00});
        i2c_start();
        write_byte(8'hA1, ack);
        check("rs_addr_ack", 32'(ack), 32'(ACK));
        check("rs_rw", 32'(bus.rw), 32'd1);
        check("rs_busy", 32'(bus.busy), 32'd1);
        read_byte(1'b1, d);
        check("rs_read", 32'(d), 32'h5A);
        i2c_stop();
        wq();

        // STOP in the middle of a data byte.
        rx0 = rx_pulses;
        i2c_start();
        write_byte(8'hA0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b1, ack);
        i2c_stop();
        wq();
        check("abort_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_no_rx", 32'(rx_pulses - rx0), 32'd0);
        i2c_start();
        write_byte(8'hA0, ack);
        check("abort_then_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        wq();

        // Reset while driving a 0 data bit of a read.
        tx_m = 8'h3C;
        sb.push_back('{is_rx: 1'b0, val: 8'h00});
        i2c_start();
        write_byte(8'hA1, ack);
        check("rst_pre_drive", 32'(bus.sda_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("rst_rw", 32'(bus.rw), 32'd0);
        check("rst_addressed", 32'(bus.addressed), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        oe0 = oe_cycles;
        tx0 = tx_pulses;
        read_byte(1'b1, d);
        check("rst_ignored_read", 32'(d), 32'hFF);
        check("rst_ignored_busy", 32'(bus.busy), 32'd0);
        check("rst_ignored_drive", 32'(oe_cycles - oe0), 32'd0);
        check("rst_ignored_tx_req", 32'(tx_pulses - tx0), 32'd0);
        i2c_stop();
        wq();
        i2c_start();
        write_byte(8'hA0, ack);
        check("rst_then_ack", 32'(ack), 32'(ACK));
        i2c_stop();
        wq();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
